// File: rtl/cache_assoc.sv
// N-way set-associative write-back, write-allocate cache with true-LRU replacement.
// Misses run a sequenced EVICT -> FILL handshake toward memory.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

module cache_assoc #(
  parameter int WIDTH = `MEMORY_WIDTH,
  parameter int SETS  = 4,
  parameter int WAYS  = 2,
  parameter     ALIAS = "cache"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             do_read,
  input  logic             do_write,
  input  logic             is_byte,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic             hit,
  output logic             mem_write_req,
  output logic [31:0]      mem_write_addr,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic             mem_write_ack,
  output logic             mem_read_req,
  output logic [31:0]      mem_read_addr,
  input  logic [WIDTH-1:0] mem_read_data,
  input  logic             mem_read_ack
);
  localparam int WB = $clog2(WIDTH) - 3;
  localparam int SB = $clog2(SETS);
  localparam int TB = 32 - WB - SB;
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, EVICT, FILL} state_t;
  state_t state, state_next;

  // ALIAS names the instance in debug builds only; no hardware depends on it.
  if ($bits(ALIAS) == 0) begin : g_unnamed
  end

  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [TB-1:0]    tag_q  [SETS][WAYS];
  logic [WIDTH-1:0] line_q [SETS][WAYS];
  logic [AW-1:0]    age_q  [SETS][WAYS];

  logic [SB-1:0] set_idx, fill_set, touch_set;
  logic [TB-1:0] tag_in, fill_tag;
  logic [WB-1:0] off, off_w;
  logic [AW-1:0] hit_way, victim, fill_way, touch_way;
  logic [WAYS-1:0] match;
  logic access, miss, victim_dirty, touch_en, found_inv;
  logic [WIDTH-1:0] hit_line, wmask, wdata, wr_line;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;

  assign access  = do_read | do_write;
  assign set_idx = addr[WB+SB-1:WB];
  assign tag_in  = addr[31:WB+SB];
  assign off     = addr[WB-1:0];
  assign off_w   = off & ~WB'(3);

  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
        match[w] = 1'b1;
        hit_way  = AW'(w);
      end
  end

  // Lowest-index invalid way wins (descending scan); otherwise the oldest way.
  always_comb begin
    victim    = '0;
    found_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[set_idx][w]) begin
        victim    = AW'(w);
        found_inv = 1'b1;
      end
    if (!found_inv)
      for (int w = 0; w < WAYS; w++)
        if (age_q[set_idx][w] == AW'(WAYS - 1)) victim = AW'(w);
  end

  assign victim_dirty = valid_q[set_idx][victim] & dirty_q[set_idx][victim];

  assign hit      = access & reset & (state == IDLE) & (|match);
  assign hit_line = line_q[set_idx][hit_way];
  assign rd_word  = 32'(hit_line >> {off_w, 3'b000});
  assign rd_byte  = 8'(hit_line >> {off, 3'b000});
  assign data_out = hit ? (is_byte ? {24'h0, rd_byte} : rd_word) : 32'h0;

  assign wmask   = is_byte ? (WIDTH'(8'hFF) << {off, 3'b000})
                           : (WIDTH'(32'hFFFF_FFFF) << {off_w, 3'b000});
  assign wdata   = is_byte ? (WIDTH'(data_in[7:0]) << {off, 3'b000})
                           : (WIDTH'(data_in) << {off_w, 3'b000});
  assign wr_line = (hit_line & ~wmask) | (wdata & wmask);

  assign touch_en  = hit | ((state == FILL) & mem_read_ack);
  assign touch_set = hit ? set_idx : fill_set;
  assign touch_way = hit ? hit_way : fill_way;

  always_comb begin
    state_next = state;
    miss       = 1'b0;
    case (state)
      IDLE:
        if (access && !(|match)) begin
          miss       = 1'b1;
          state_next = victim_dirty ? EVICT : FILL;
        end
      EVICT:   if (mem_write_ack) state_next = FILL;
      FILL:    if (mem_read_ack)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AW'(w);
      mem_write_req  <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      mem_read_req   <= 1'b0;
      mem_read_addr  <= '0;
    end else begin
      state <= state_next;
      if (touch_en)
        for (int w = 0; w < WAYS; w++)
          if (AW'(w) == touch_way)
            age_q[touch_set][w] <= '0;
          else if (age_q[touch_set][w] < age_q[touch_set][touch_way])
            age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
      if (hit && do_write) begin
        line_q[set_idx][hit_way]  <= wr_line;
        dirty_q[set_idx][hit_way] <= 1'b1;
      end
      if (miss) begin
        valid_q[set_idx][victim] <= 1'b0;
        fill_set <= set_idx;
        fill_tag <= tag_in;
        fill_way <= victim;
        if (victim_dirty) begin
          mem_write_req  <= 1'b1;
          mem_write_addr <= {tag_q[set_idx][victim], set_idx, WB'(0)};
          mem_write_data <= line_q[set_idx][victim];
        end else begin
          mem_read_req  <= 1'b1;
          mem_read_addr <= {tag_in, set_idx, WB'(0)};
        end
      end
      if (state == EVICT && mem_write_ack) begin
        mem_write_req <= 1'b0;
        mem_read_req  <= 1'b1;
        mem_read_addr <= {fill_tag, fill_set, WB'(0)};
      end
      if (state == FILL && mem_read_ack) begin
        line_q[fill_set][fill_way]  <= mem_read_data;
        tag_q[fill_set][fill_way]   <= fill_tag;
        valid_q[fill_set][fill_way] <= 1'b1;
        dirty_q[fill_set][fill_way] <= 1'b0;
        mem_read_req                <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc (128-bit lines, 2 sets, 2 ways); read data
// expectations are queued at issue time and popped when the cache hits.
module tb_cache_assoc;
  localparam int WIDTH = 128;
  localparam logic [127:0] L0  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] L0E = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_EEAAAAAA;
  localparam logic [127:0] L1  = 128'h13131313_12121212_11111111_10101010;
  localparam logic [127:0] L1D = 128'h13131313_12121212_12345678_10101010;
  localparam logic [127:0] L2  = 128'h43434343_42424242_41414141_40404040;

  logic clk = 1'b0;
  logic reset, do_read, do_write, is_byte, hit;
  logic [31:0] addr, data_in, data_out;
  logic mem_write_req, mem_write_ack, mem_read_req, mem_read_ack;
  logic [31:0] mem_write_addr, mem_read_addr;
  logic [WIDTH-1:0] mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  cache_assoc #(.WIDTH(WIDTH), .SETS(2), .WAYS(2), .ALIAS("tb_cache")) dut (
    .clk(clk), .reset(reset), .addr(addr), .do_read(do_read), .do_write(do_write),
    .is_byte(is_byte), .data_in(data_in), .data_out(data_out), .hit(hit),
    .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_ack(mem_write_ack),
    .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic b, input logic [31:0] d, input logic [31:0] exp);
    do_read = rd; do_write = wr; addr = a; is_byte = b; data_in = d;
    if (rd && !wr) sb.push_back(exp);
  endtask

  // Waits (bounded) for hit, scores read data, then lets the access commit.
  task automatic complete(input string tag, input int max_wait);
    int n = 0;
    logic [31:0] exp;
    @(negedge clk);
    while (!hit && n < max_wait) begin @(negedge clk); n++; end
    chk({tag, ":hit"}, hit, 1);
    if (do_read && !do_write) begin
      exp = 32'hDEAD_BEEF;
      if (sb.size() > 0) exp = sb.pop_front();
      chk({tag, ":data"}, data_out, exp);
    end
    @(posedge clk); #1;
    do_read = 0; do_write = 0; is_byte = 0;
  endtask

  task automatic serve_fill(input string tag, input logic [31:0] exp_addr, input logic [127:0] line);
    int n = 0;
    while (!mem_read_req && n < 20) begin @(negedge clk); n++; end
    chk({tag, ":rd_req"}, mem_read_req, 1);
    chk({tag, ":rd_addr"}, mem_read_addr, exp_addr);
    chk({tag, ":wr_req_low"}, mem_write_req, 0);
    mem_read_data = line; mem_read_ack = 1;
    @(posedge clk); #1;
    mem_read_ack = 0;
    chk({tag, ":rd_req_drop"}, mem_read_req, 0);
  endtask

  task automatic serve_evict(input string tag, input logic [31:0] exp_addr,
                             input logic [127:0] exp_line, input int hold);
    int n = 0;
    while (!mem_write_req && n < 20) begin @(negedge clk); n++; end
    chk({tag, ":wr_req"}, mem_write_req, 1);
    chk({tag, ":wr_addr"}, mem_write_addr, exp_addr);
    chk({tag, ":wr_data"}, mem_write_data, exp_line);
    chk({tag, ":rd_req_low"}, mem_read_req, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ":wr_req_hold"}, mem_write_req, 1);
      chk({tag, ":wr_addr_hold"}, mem_write_addr, exp_addr);
      chk({tag, ":rd_req_hold_low"}, mem_read_req, 0);
      chk({tag, ":hit_low"}, hit, 0);
    end
    mem_write_ack = 1;
    @(posedge clk); #1;
    mem_write_ack = 0;
    chk({tag, ":wr_req_drop"}, mem_write_req, 0);
    chk({tag, ":rd_req_after_ack"}, mem_read_req, 1);
  endtask

  initial begin
    reset = 0; do_read = 1; do_write = 0; addr = 32'h4; is_byte = 0; data_in = 0;
    mem_write_ack = 0; mem_read_ack = 0; mem_read_data = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst:hit", hit, 0);
      chk("rst:data_out", data_out, 0);
      chk("rst:rd_req", mem_read_req, 0);
      chk("rst:wr_req", mem_write_req, 0);
    end
    @(posedge clk); #1;
    reset = 1; do_read = 0;

    // clean miss, one-cycle request latency, then word and byte hits
    issue(1, 0, 32'h004, 0, 0, 32'hBBBBBBBB);
    @(negedge clk);
    chk("miss:hit", hit, 0);
    chk("miss:rd_req_early", mem_read_req, 0);
    @(negedge clk);
    chk("miss:rd_req_1cyc", mem_read_req, 1);
    serve_fill("fill000", 32'h000, L0);
    complete("rd004", 0);
    issue(1, 0, 32'h005, 1, 0, 32'h000000BB);
    complete("rdb005", 0);

    // LRU: 0x020 becomes the victim for 0x040 with no writeback
    issue(1, 0, 32'h020, 0, 0, 32'h10101010);
    serve_fill("fill020", 32'h020, L1);
    complete("rd020", 0);
    issue(1, 0, 32'h000, 0, 0, 32'hAAAAAAAA);
    complete("rd000a", 0);
    issue(1, 0, 32'h040, 0, 0, 32'h40404040);
    serve_fill("fill040", 32'h040, L2);
    complete("rd040", 0);
    issue(1, 0, 32'h000, 0, 0, 32'hAAAAAAAA);
    complete("rd000b", 0);
    chk("rd000b:no_rd_req", mem_read_req, 0);

    // dirty eviction ordering
    issue(0, 1, 32'h024, 0, 32'h12345678, 0);
    serve_fill("fill020b", 32'h020, L1);
    complete("wr024", 0);
    issue(1, 0, 32'h000, 0, 0, 32'hAAAAAAAA);
    complete("rd000c", 0);
    issue(1, 0, 32'h040, 0, 0, 32'h40404040);
    @(negedge clk);
    chk("dmiss:hit", hit, 0);
    serve_evict("evict020", 32'h020, L1D, 2);
    serve_fill("fill040b", 32'h040, L2);
    chk("keep:wr_addr", mem_write_addr, 32'h020);
    chk("keep:wr_data", mem_write_data, L1D);
    complete("rd040b", 0);

    // byte write merges into the line and marks it dirty
    issue(0, 1, 32'h003, 1, 32'h123456EE, 0);
    complete("wrb003", 0);
    issue(1, 0, 32'h000, 0, 0, 32'hEEAAAAAA);
    complete("rd000d", 0);
    issue(1, 0, 32'h040, 0, 0, 32'h40404040);
    complete("rd040c", 0);
    issue(1, 0, 32'h020, 0, 0, 32'h10101010);
    serve_evict("evict000", 32'h000, L0E, 0);
    serve_fill("fill020c", 32'h020, L1D);
    complete("rd020c", 0);

    // reset mid-FILL; a later ack with req low is ignored
    issue(1, 0, 32'h000, 0, 0, 32'hEEAAAAAA);
    for (int n = 0; n < 20 && !mem_read_req; n++) @(negedge clk);
    chk("rstfill:rd_req", mem_read_req, 1);
    reset = 0;
    #1;
    chk("rstfill:hit", hit, 0);
    chk("rstfill:data_out", data_out, 0);
    @(posedge clk); #1;
    chk("rstfill:req_drop", mem_read_req, 0);
    chk("rstfill:wr_req", mem_write_req, 0);
    reset = 1; mem_read_data = L0E; mem_read_ack = 1;
    @(posedge clk); #1;
    mem_read_ack = 0;
    chk("stray_ack:hit", hit, 0);
    chk("stray_ack:rd_req", mem_read_req, 1);
    serve_fill("refill000", 32'h000, L0E);
    complete("rd000e", 0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
